// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time helpers for the CORDIC engine:
// operating mode, FSM state encoding, and the fixed-point atan and gain tables.
package cordic_pkg;

    typedef enum logic {ROTATE = 1'b0, VECTOR = 1'b1} cordic_mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREROT = 3'd1,
        ITER   = 3'd2,
        SCALE  = 3'd3,
        DONE   = 3'd4
    } cordic_state_e;

    localparam real PI        = 3.14159265358979323846;
    localparam real PI_OVER_2 = PI / 2.0;

    // Tables are derived in 40-bit integer fixed point, then rounded to the target precision.
    localparam int CALC_FB = 40;

    // atan(1/m) by its Taylor series; converges quickly for m >= 2.
    function automatic longint atan_inv(input longint m);
        longint p;
        longint sum;
        sum = 0;
        p = (longint'(1) <<< CALC_FB) / m;
        for (int n = 0; n < 40 && p != 0; n++) begin
            if (n % 2 == 0) sum += p / (2 * n + 1);
            else            sum -= p / (2 * n + 1);
            p = p / (m * m);
        end
        return sum;
    endfunction

    function automatic longint atan_entry(input int i, input int fb);
        longint a;
        if (i == 0) a = 4 * atan_inv(5) - atan_inv(239);
        else        a = atan_inv(longint'(1) <<< i);
        return (a + (longint'(1) <<< (CALC_FB - fb - 1))) >>> (CALC_FB - fb);
    endfunction

    // K = prod 1/sqrt(1+2^-2i): K^2 in 2^30 scale, then integer square root.
    function automatic longint gain_k(input int iters, input int fb);
        longint k2;
        longint v;
        longint r;
        longint t;
        k2 = longint'(1) <<< 30;
        for (int i = 0; i < iters; i++) begin
            if (i < 16) k2 = (k2 <<< (2 * i)) / ((longint'(1) <<< (2 * i)) + 1);
        end
        v = k2 <<< 30;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (longint'(1) <<< b);
            if (t * t <= v) r = t;
        end
        return (r + (longint'(1) <<< (30 - fb - 1))) >>> (30 - fb);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup, contents computed from cordic_pkg at elaboration.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int IW         = 18,
    parameter int FB         = 12,
    parameter int ITERATIONS = 14,
    parameter int CW         = 4
) (
    input  logic [CW-1:0]        idx,
    output logic signed [IW-1:0] atan
);

    logic signed [IW-1:0] rom [ITERATIONS];

    generate
        for (genvar gi = 0; gi < ITERATIONS; gi++) begin : g_rom
            assign rom[gi] = IW'(atan_entry(gi, FB));
        end
    endgenerate

    always_comb begin
        atan = '0;
        for (int i = 0; i < ITERATIONS; i++) begin
            if (idx == CW'(i)) atan = rom[i];
        end
    end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine (rotation / vectoring), one operation in flight.
// Define CORDIC_GAIN_COMP_EN to add the SCALE state that removes the CORDIC gain.
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int FRACTIONAL_BITS = 12,
    parameter int ITERATIONS      = 14,
    parameter int GUARD_BITS      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);

    localparam int IW = WIDTH + GUARD_BITS;
    localparam int CW = $clog2(ITERATIONS + 1);
    localparam int PW = IW + FRACTIONAL_BITS + 3;

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_PREROT = PREROT;
    localparam logic [2:0] ST_ITER   = ITER;
    localparam logic [2:0] ST_SCALE  = SCALE;
    localparam logic [2:0] ST_DONE   = DONE;

    localparam logic [CW-1:0]        LAST_IDX = CW'(ITERATIONS - 1);
    localparam logic signed [IW-1:0] PI_FX    = IW'($rtoi(PI * (2 ** FRACTIONAL_BITS) + 0.5));
    localparam logic signed [IW-1:0] PI_2_FX  = IW'($rtoi(PI_OVER_2 * (2 ** FRACTIONAL_BITS) + 0.5));
    localparam logic signed [PW-1:0] OUT_MAX  = PW'((longint'(1) <<< (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] OUT_MIN  = PW'(-(longint'(1) <<< (WIDTH - 1)));

    logic [2:0]              state_reg, state_next;
    cordic_mode_e            mode_reg, mode_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic signed [IW-1:0]    x_reg, y_reg, z_reg;
    logic signed [IW-1:0]    x_next, y_next, z_next;
    logic                    in_ready_reg;
    logic signed [WIDTH-1:0] x_out_reg, y_out_reg, z_out_reg;
    logic signed [WIDTH-1:0] x_res, y_res, z_res;
    logic                    out_load;

    logic                    dir_pos;
    logic signed [IW-1:0]    x_shift, y_shift, atan_val;
    logic signed [IW-1:0]    x_iter, y_iter, z_iter;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > OUT_MAX) return OUT_MAX[WIDTH-1:0];
        if (v < OUT_MIN) return OUT_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    cordic_atan_rom #(
        .IW         (IW),
        .FB         (FRACTIONAL_BITS),
        .ITERATIONS (ITERATIONS),
        .CW         (CW)
    ) u_atan_rom (
        .idx  (cnt_reg),
        .atan (atan_val)
    );

    // d = +1 when z >= 0 (rotation) or y < 0 (vectoring).
    assign dir_pos = (mode_reg == VECTOR) ? y_reg[IW-1] : ~z_reg[IW-1];
    assign x_shift = x_reg >>> cnt_reg;
    assign y_shift = y_reg >>> cnt_reg;
    assign x_iter  = dir_pos ? x_reg - y_shift : x_reg + y_shift;
    assign y_iter  = dir_pos ? y_reg + x_shift : y_reg - x_shift;
    assign z_iter  = dir_pos ? z_reg - atan_val : z_reg + atan_val;

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [PW-1:0] K_FX = PW'(gain_k(ITERATIONS, FRACTIONAL_BITS));
    localparam logic signed [PW-1:0] HALF = PW'(longint'(1) <<< (FRACTIONAL_BITS - 1));
    logic signed [PW-1:0] x_scaled, y_scaled;

    assign x_scaled = (PW'(x_reg) * K_FX + HALF) >>> FRACTIONAL_BITS;
    assign y_scaled = (PW'(y_reg) * K_FX + HALF) >>> FRACTIONAL_BITS;
    assign x_res    = sat(x_scaled);
    assign y_res    = sat(y_scaled);
    assign z_res    = sat(PW'(z_reg));
`else
    assign x_res = sat(PW'(x_iter));
    assign y_res = sat(PW'(y_iter));
    assign z_res = sat(PW'(z_iter));
`endif

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        cnt_next   = cnt_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid && in_ready_reg) begin
                    state_next = ST_PREROT;
                    mode_next  = cordic_mode_e'(mode);
                    x_next     = IW'(x_in);
                    y_next     = IW'(y_in);
                    z_next     = IW'(z_in);
                end
            end
            ST_PREROT: begin
                state_next = ST_ITER;
                cnt_next   = '0;
                // Fold the operand into the convergence range of the iterations.
                if (mode_reg == ROTATE) begin
                    if (z_reg > PI_2_FX) begin
                        x_next = -x_reg;
                        y_next = -y_reg;
                        z_next = z_reg - PI_FX;
                    end else if (z_reg < -PI_2_FX) begin
                        x_next = -x_reg;
                        y_next = -y_reg;
                        z_next = z_reg + PI_FX;
                    end
                end else if (x_reg[IW-1]) begin
                    x_next = -x_reg;
                    y_next = -y_reg;
                    z_next = y_reg[IW-1] ? z_reg - PI_FX : z_reg + PI_FX;
                end
            end
            ST_ITER: begin
                x_next   = x_iter;
                y_next   = y_iter;
                z_next   = z_iter;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == LAST_IDX) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_next = ST_SCALE;
`else
                    state_next = ST_DONE;
`endif
                end
            end
            ST_SCALE: state_next = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign out_load = (state_next == ST_DONE) && (state_reg != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= ROTATE;
            cnt_reg      <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            z_reg        <= '0;
            in_ready_reg <= 1'b0;
            x_out_reg    <= '0;
            y_out_reg    <= '0;
            z_out_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            cnt_reg      <= cnt_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            z_reg        <= z_next;
            in_ready_reg <= (state_next == ST_IDLE);
            if (out_load) begin
                x_out_reg <= x_res;
                y_out_reg <= y_res;
                z_out_reg <= z_res;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg == ST_DONE);
    assign x_out     = x_out_reg;
    assign y_out     = y_out_reg;
    assign z_out     = z_out_reg;

endmodule
